sync_debounce_edge: RTL and testbench
=====================================

// Module: sync_debounce_edge
// PURPOSE
//  Multi-channel input conditioner for asynchronous level signals entering a single clock domain.
//  Per channel it has three stages:
//    - a parametrised-depth synchronizer chain
//    - a consecutive-cycle debounce filter
//    - one-cycle rise/fall pulse generators, plus a sticky event flag with a per-channel clear.
//  Sits at the boundary between off-chip/foreign-domain levels (buttons, status lines, slow
//  handshakes) and core logic.
// PARAMETERS
//  CHANNELS         4  number of independent input channels (>=1)
//  SYNC_STAGES      2  synchronizer flops per channel (>=2)
//  DEBOUNCE_CYCLES  4  consecutive mismatching cycles required before stable_out updates (>=1)
//  RESET_VALUE   1'b0  reset value of every synchronizer flop and of stable_out, all channels
// PORTS
//  clk           in   1         single clock; all flops rising-edge
//  async_reset   in   1         asynchronous assert, active-low
//  async_in      in   CHANNELS  asynchronous level inputs
//  clear_events  in   CHANNELS  clk-synchronous; bit i=1 clears event_sticky[i]
//  sync_out      out  CHANNELS  last synchronizer stage, unfiltered
//  stable_out    out  CHANNELS  debounced level (registered)
//  rise_pulse    out  CHANNELS  one-cycle pulse: stable_out went 0->1 (registered)
//  fall_pulse    out  CHANNELS  one-cycle pulse: stable_out went 1->0 (registered)
//  event_sticky  out  CHANNELS  set by rise or fall; held until cleared (registered)
//  any_event     out  1         combinational OR of event_sticky
// BEHAVIOUR
//  Reset (async_reset=0, takes effect immediately, independent of clk):
//    - sync chain and stable_out = RESET_VALUE
//    - debounce counters = 0
//    - rise_pulse, fall_pulse, event_sticky = 0
//  Release of reset produces no pulses on its own, even if async_in != RESET_VALUE;
//    any change must first pass the full sync + debounce path.
//  Synchronizer: shift chain per channel. A level present at async_in at edge k appears on
//    sync_out after edge k+SYNC_STAGES-1 (SYNC_STAGES edges including k). No other logic
//    samples async_in.
//  Debounce: per-channel counter, width $clog2(DEBOUNCE_CYCLES+1).
//    - mismatch = sync_out != stable_out
//    - mismatch & cnt < DEBOUNCE_CYCLES-1  -> cnt++
//    - mismatch & cnt == DEBOUNCE_CYCLES-1 -> stable_out <= sync_out; cnt <= 0
//    - no mismatch                         -> cnt <= 0 (any single matching cycle restarts)
//    - Latency sync_out change -> stable_out change = DEBOUNCE_CYCLES edges.
//      DEBOUNCE_CYCLES=1 gives a plain 1-cycle register.
//    - Counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
//  Edges:
//    - rise_pulse[i] = 1 in exactly the cycle stable_out[i] first shows 1; same for
//      fall_pulse[i] with 0.
//    - Both are 0 otherwise; they are never both 1.
//    - Back-to-back toggles are separated by at least DEBOUNCE_CYCLES cycles.
//  Sticky:
//    - event_sticky[i] is set at the same edge rise/fall_pulse[i] asserts.
//    - clear_events[i]=1 clears it at the next edge.
//    - Simultaneous set and clear: set wins (sticky stays/becomes 1).
//    - Clear with no set pending: 0 next cycle.
//  Channels are fully independent; simultaneous activity on all channels is legal.
// TESTING  (defaults: CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_VALUE=0)
//  1 Reset/latency:
//    - reset low with async_in=4'hF -> all outputs 0.
//    - release, then raise async_in[0] before edge E0 -> sync_out[0]=1 after E1.
//    - stable_out[0]=1, rise_pulse[0]=1, event_sticky[0]=1 after E5; rise_pulse[0]=0 after E6.
//  2 Glitch reject: async_in[1]=1 for 3 cycles then 0 -> stable_out[1], pulses, sticky all
//    remain 0.
//  3 Restart: async_in[2] high 3 cycles, low 1 cycle (as seen at sync_out), then high
//    -> stable_out[2] rises exactly 4 cycles after sync_out[2] returns high.
//  4 Sticky priority:
//    - clear_events[2]=1 in the same cycle fall_pulse[2] sets -> event_sticky[2]=1.
//    - next clear -> 0; any_event follows.
//  5 Reset mid-operation:
//    - drop async_reset while ch3 counter=2 and stable_out[3]=0 -> outputs stay 0,
//      counter=0, no pulse.
//    - release with async_in[3]=1 -> rise_pulse[3] exactly SYNC_STAGES+DEBOUNCE_CYCLES
//      edges later.
//  6 Parallel: async_in 4'h0->4'hF in one cycle -> rise_pulse=4'hF for exactly one cycle.
//    - later 4'hF->4'h5 -> fall_pulse=4'hA for one cycle, with no rise_pulse.

Source files
------------

// File: rtl/sync_debounce_edge_if.sv
// Bundle of per-channel level inputs and conditioned outputs
// for the multi-channel synchronize / debounce / edge block.
interface sync_debounce_edge_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] async_in;
  logic [CHANNELS-1:0] clear_events;
  logic [CHANNELS-1:0] sync_out;
  logic [CHANNELS-1:0] stable_out;
  logic [CHANNELS-1:0] rise_pulse;
  logic [CHANNELS-1:0] fall_pulse;
  logic [CHANNELS-1:0] event_sticky;
  logic                any_event;

  modport master (
    output async_in,
    output clear_events,
    input  sync_out,
    input  stable_out,
    input  rise_pulse,
    input  fall_pulse,
    input  event_sticky,
    input  any_event
  );

  modport slave (
    input  async_in,
    input  clear_events,
    output sync_out,
    output stable_out,
    output rise_pulse,
    output fall_pulse,
    output event_sticky,
    output any_event
  );
endinterface

// File: rtl/sync_debounce_edge.sv
// Per-channel synchronizer chain, consecutive-cycle debounce,
// registered rise/fall pulses and sticky event flags.
module sync_debounce_edge #(
  parameter int   CHANNELS        = 4,
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RESET_VALUE     = 1'b0
) (
  input logic               clk,
  input logic               async_reset,
  sync_debounce_edge_if.slave bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CHANNELS-1:0] RST_VEC =
    {CHANNELS{RESET_VALUE}};

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CW-1:0]       cnt_q  [CHANNELS];
  logic [CHANNELS-1:0] stable_q;
  logic [CHANNELS-1:0] rise_q;
  logic [CHANNELS-1:0] fall_q;
  logic [CHANNELS-1:0] sticky_q;
  logic [CHANNELS-1:0] sync_w;
  logic [CHANNELS-1:0] mismatch;
  logic [CHANNELS-1:0] hit;

  assign sync_w   = sync_q[SYNC_STAGES-1];
  assign mismatch = sync_w ^ stable_q;

  // Shift the raw inputs through the metastability chain
  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= RST_VEC;
      end
    end else begin
      sync_q[0] <= bus.async_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // A channel commits when its mismatch run reaches the last count
  always_comb begin
    hit = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      hit[c] = mismatch[c] && (cnt_q[c] == CNT_LAST);
    end
  end

  // Count consecutive mismatching cycles; any match restarts
  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (!mismatch[c] || hit[c]) begin
          cnt_q[c] <= '0;
        end else begin
          cnt_q[c] <= cnt_q[c] + 1'b1;
        end
      end
    end
  end

  // Debounced level, edge pulses and sticky flags (set beats clear)
  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      stable_q <= RST_VEC;
      rise_q   <= '0;
      fall_q   <= '0;
      sticky_q <= '0;
    end else begin
      stable_q <= stable_q ^ hit;
      rise_q   <= hit & sync_w;
      fall_q   <= hit & ~sync_w;
      sticky_q <= hit | (sticky_q & ~bus.clear_events);
    end
  end

  assign bus.sync_out     = sync_w;
  assign bus.stable_out   = stable_q;
  assign bus.rise_pulse   = rise_q;
  assign bus.fall_pulse   = fall_q;
  assign bus.event_sticky = sticky_q;
  assign bus.any_event    = |sticky_q;

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Directed plus randomized bench for sync_debounce_edge,
// checked against a window-based behavioural model.
module tb_sync_debounce_edge;

  localparam int   CH = 4;
  localparam int   S  = 2;
  localparam int   D  = 4;
  localparam logic RV = 1'b0;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   n;

  sync_debounce_edge_if #(.CHANNELS(CH)) bus ();

  sync_debounce_edge #(
    .CHANNELS(CH),
    .SYNC_STAGES(S),
    .DEBOUNCE_CYCLES(D),
    .RESET_VALUE(RV)
  ) dut (
    .clk(clk),
    .async_reset(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Model: sync_out is the input sampled S-1 edges earlier;
  // stable flips once the last D pre-edge sync values all
  // differ from it (history is forgotten on reset).
  logic [CH-1:0] m_sync   = '0;
  logic [CH-1:0] m_stable = '0;
  logic [CH-1:0] m_rise   = '0;
  logic [CH-1:0] m_fall   = '0;
  logic [CH-1:0] m_sticky = '0;
  logic [CH-1:0] m_flip;
  logic          m_all;
  logic [CH-1:0] ain_q [$];
  logic [CH-1:0] win   [$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sync   = {CH{RV}};
      m_stable = {CH{RV}};
      m_rise   = '0;
      m_fall   = '0;
      m_sticky = '0;
      ain_q.delete();
      win.delete();
    end else begin
      win.push_back(m_sync);
      if (win.size() > D) void'(win.pop_front());
      m_flip = '0;
      if (win.size() == D) begin
        for (int c = 0; c < CH; c++) begin
          m_all = 1'b1;
          foreach (win[j]) begin
            if (win[j][c] == m_stable[c]) m_all = 1'b0;
          end
          m_flip[c] = m_all;
        end
      end
      m_rise   = m_flip & ~m_stable;
      m_fall   = m_flip & m_stable;
      m_stable = m_stable ^ m_flip;
      m_sticky = m_flip | (m_sticky & ~bus.clear_events);
      ain_q.push_back(bus.async_in);
      if (ain_q.size() > S) void'(ain_q.pop_front());
      m_sync = (ain_q.size() == S) ? ain_q[0] : {CH{RV}};
    end
  end

  task automatic chk(input string tag,
                     input logic [CH-1:0] got,
                     input logic [CH-1:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic check_all();
    chk("sync_out", bus.sync_out, m_sync);
    chk("stable_out", bus.stable_out, m_stable);
    chk("rise_pulse", bus.rise_pulse, m_rise);
    chk("fall_pulse", bus.fall_pulse, m_fall);
    chk("event_sticky", bus.event_sticky, m_sticky);
    chk("any_event", {3'b0, bus.any_event},
        {3'b0, |m_sticky});
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.async_in = 4'hF;
    bus.clear_events = 4'h0;

    // 1: reset state and first-transaction latency
    @(negedge clk);
    check_all();
    chk("rst_stable", bus.stable_out, 4'h0);
    chk("rst_sync", bus.sync_out, 4'h0);
    chk("rst_sticky", bus.event_sticky, 4'h0);
    bus.async_in = 4'h1;
    rst_n = 1'b1;
    step();
    chk("e0_sync0", {3'b0, bus.sync_out[0]}, 4'h0);
    step();
    chk("e1_sync0", {3'b0, bus.sync_out[0]}, 4'h1);
    step();
    step();
    step();
    chk("e4_stable0", {3'b0, bus.stable_out[0]}, 4'h0);
    step();
    chk("e5_stable0", {3'b0, bus.stable_out[0]}, 4'h1);
    chk("e5_rise0", bus.rise_pulse, 4'h1);
    chk("e5_sticky0", {3'b0, bus.event_sticky[0]}, 4'h1);
    chk("e5_rise_no_reset_pulse", bus.rise_pulse & 4'hE, 4'h0);
    step();
    chk("e6_rise0", bus.rise_pulse, 4'h0);

    // 2: three-cycle glitch is rejected
    bus.async_in[1] = 1'b1;
    repeat (3) step();
    bus.async_in[1] = 1'b0;
    repeat (8) step();
    chk("glitch_stable1", {3'b0, bus.stable_out[1]}, 4'h0);
    chk("glitch_sticky1", {3'b0, bus.event_sticky[1]}, 4'h0);

    // 3: a single matching cycle restarts the count
    bus.async_in[2] = 1'b1;
    repeat (3) step();
    bus.async_in[2] = 1'b0;
    step();
    bus.async_in[2] = 1'b1;
    n = 0;
    do begin step(); n++; end
    while (!bus.sync_out[2] && n < 10);
    chk("restart_sync_bound", {3'b0, bus.sync_out[2]}, 4'h1);
    n = 0;
    do begin step(); n++; end
    while (!bus.stable_out[2] && n < 20);
    chk("restart_latency", 4'(n), 4'd4);
    chk("restart_rise2", bus.rise_pulse, 4'h4);

    // 4: set beats clear in the same cycle
    bus.clear_events = 4'hF;
    step();
    chk("clear_all_any", {3'b0, bus.any_event}, 4'h0);
    bus.clear_events = 4'h0;
    bus.async_in[2] = 1'b0;
    repeat (5) step();
    bus.clear_events[2] = 1'b1;
    step();
    chk("prio_fall2", bus.fall_pulse, 4'h4);
    chk("prio_sticky2", {3'b0, bus.event_sticky[2]}, 4'h1);
    chk("prio_any", {3'b0, bus.any_event}, 4'h1);
    step();
    chk("prio_cleared2", {3'b0, bus.event_sticky[2]}, 4'h0);
    chk("prio_any_low", {3'b0, bus.any_event}, 4'h0);
    bus.clear_events = 4'h0;

    // 5: reset in the middle of a ch3 debounce run
    bus.async_in[3] = 1'b1;
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1 check_all();
    chk("midrst_stable", bus.stable_out, 4'h0);
    chk("midrst_rise", bus.rise_pulse, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin step(); n++; end
    while (!bus.rise_pulse[3] && n < 20);
    chk("midrst_rise3_latency", 4'(n), 4'(S + D));

    // 6: all channels in parallel
    bus.async_in = 4'h0;
    repeat (10) step();
    bus.async_in = 4'hF;
    n = 0;
    do begin step(); n++; end
    while (bus.rise_pulse == 4'h0 && n < 20);
    chk("par_rise", bus.rise_pulse, 4'hF);
    chk("par_rise_nofall", bus.fall_pulse, 4'h0);
    step();
    chk("par_rise_once", bus.rise_pulse, 4'h0);
    bus.async_in = 4'h5;
    n = 0;
    do begin step(); n++; end
    while (bus.fall_pulse == 4'h0 && n < 20);
    chk("par_fall", bus.fall_pulse, 4'hA);
    chk("par_fall_norise", bus.rise_pulse, 4'h0);
    step();
    chk("par_fall_once", bus.fall_pulse, 4'h0);

    // random traffic with clears and occasional resets
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 5) == 0)
          bus.async_in[c] = ~bus.async_in[c];
      end
      bus.clear_events = ($urandom_range(0, 5) == 0) ?
        4'($urandom) : 4'h0;
      if ($urandom_range(0, 120) == 0) begin
        rst_n = 1'b0;
        #1 check_all();
        @(negedge clk);
        rst_n = 1'b1;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
